// File: rtl/bus_region_decoder_if.sv
// CPU-bus side of the region decoder: master request, slave acks, select and fault monitor.
// The master modport is the environment view (CPU master plus slave acks).
interface bus_region_decoder_if #(
   parameter int unsigned AW     = 32,
   parameter int unsigned NSLAVE = 9
);
   logic              cyc_i;
   logic              stb_i;
   logic [AW-1:0]     adr_i;
   logic [NSLAVE-1:0] s_ack_i;
   logic [NSLAVE-1:0] sel_o;
   logic              ack_o;
   logic              err_o;
   logic              fault_valid_o;
   logic [1:0]        fault_code_o;
   logic [AW-1:0]     fault_adr_o;
   logic              fault_clr_i;

   modport master (
      output cyc_i, stb_i, adr_i, s_ack_i, fault_clr_i,
      input  sel_o, ack_o, err_o, fault_valid_o, fault_code_o, fault_adr_o
   );

   modport slave (
      input  cyc_i, stb_i, adr_i, s_ack_i, fault_clr_i,
      output sel_o, ack_o, err_o, fault_valid_o, fault_code_o, fault_adr_o
   );
endinterface

// File: rtl/bus_region_decoder.sv
// Registered NSLAVE-region address decoder with per-transaction FSM, slave timeout
// and a sticky first-fault register for the bus monitor.
module bus_region_decoder #(
   parameter int unsigned             AW      = 32,
   parameter int unsigned             NSLAVE  = 9,
   parameter logic [NSLAVE*AW-1:0]    LO      = {32'hffc00000, 32'hff400100, 32'hff400030,
                                                 32'hff400020, 32'hff400010, 32'hff400000,
                                                 32'hfe000000, 32'h00800000, 32'h00000000},
   parameter logic [NSLAVE*AW-1:0]    HI      = {32'hffffffff, 32'hff4013ff, 32'hff40003f,
                                                 32'hff40002f, 32'hff40001f, 32'hff40000f,
                                                 32'hfe3fffff, 32'h00ffffff, 32'h0007ffff},
   parameter int unsigned             TIMEOUT = 255
) (
   input logic                clk_i,
   input logic                rst_i,
   bus_region_decoder_if.slave bus
);

   localparam int unsigned    CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_e;

   state_e            state_q, state_d;
   logic [NSLAVE-1:0] sel_q, sel_d;
   logic              err_q, err_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     adr_q, adr_d;
   logic              fault_valid_q, fault_valid_d;
   logic [1:0]        fault_code_q, fault_code_d;
   logic [AW-1:0]     fault_adr_q, fault_adr_d;

   logic [NSLAVE-1:0] hit_vec;
   logic              hit;
   logic              found;
   logic              ack;
   logic              cap_miss;
   logic              cap_to;

   // Lowest-indexed matching region wins, keeping the select one-hot under overlap.
   always_comb begin
      hit_vec = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < NSLAVE; i++) begin
         if (!found && bus.adr_i >= LO[i*AW +: AW] && bus.adr_i <= HI[i*AW +: AW]) begin
            hit_vec[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign hit = found;
   assign ack = |(bus.s_ack_i & sel_q);

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      err_d         = 1'b0;
      cnt_d         = cnt_q;
      adr_d         = adr_q;
      fault_valid_d = fault_valid_q;
      fault_code_d  = fault_code_q;
      fault_adr_d   = fault_adr_q;
      cap_miss      = 1'b0;
      cap_to        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.cyc_i && bus.stb_i) begin
               adr_d = bus.adr_i;
               if (hit) begin
                  sel_d   = hit_vec;
                  cnt_d   = '0;
                  state_d = ACTIVE;
               end else begin
                  err_d    = 1'b1;
                  cap_miss = 1'b1;
                  state_d  = ERR;
               end
            end
         end
         ACTIVE: begin
            // Ack outranks a timeout landing on the same cycle.
            if (ack || !bus.cyc_i) begin
               sel_d   = '0;
               state_d = IDLE;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               sel_d   = '0;
               err_d   = 1'b1;
               cap_to  = 1'b1;
               state_d = ERR;
            end else if (cnt_q != {CW{1'b1}}) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            sel_d   = '0;
            state_d = IDLE;
         end
      endcase

      // A clear in the capture cycle re-arms the register, so the new fault lands.
      if ((cap_miss || cap_to) && (!fault_valid_q || bus.fault_clr_i)) begin
         fault_valid_d = 1'b1;
         fault_code_d  = cap_miss ? 2'b01 : 2'b10;
         fault_adr_d   = cap_miss ? bus.adr_i : adr_q;
      end else if (bus.fault_clr_i) begin
         fault_valid_d = 1'b0;
         fault_code_d  = 2'b00;
         fault_adr_d   = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         sel_q         <= '0;
         err_q         <= 1'b0;
         cnt_q         <= '0;
         adr_q         <= '0;
         fault_valid_q <= 1'b0;
         fault_code_q  <= 2'b00;
         fault_adr_q   <= '0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         err_q         <= err_d;
         cnt_q         <= cnt_d;
         adr_q         <= adr_d;
         fault_valid_q <= fault_valid_d;
         fault_code_q  <= fault_code_d;
         fault_adr_q   <= fault_adr_d;
      end
   end

   assign bus.sel_o         = sel_q;
   assign bus.ack_o         = ack;
   assign bus.err_o         = err_q;
   assign bus.fault_valid_o = fault_valid_q;
   assign bus.fault_code_o  = fault_code_q;
   assign bus.fault_adr_o   = fault_adr_q;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Randomised and directed bench for bus_region_decoder against a transaction-level
// model: region table lookup, ack/timeout outcome and first-fault register.
module tb_bus_region_decoder;
   localparam int AW = 32;
   localparam int NS = 9;
   localparam int TO = 8;

   // Regions 0 and 1 overlap over 0x0000_0000..0x0000_ffff.
   localparam logic [31:0] R_LO [NS] = '{32'h00000000, 32'h00000000, 32'hfe000000,
                                         32'hff400000, 32'hff400010, 32'hff400020,
                                         32'hff400030, 32'hff400100, 32'hffc00000};
   localparam logic [31:0] R_HI [NS] = '{32'h0000ffff, 32'h0007ffff, 32'hfe3fffff,
                                         32'hff40000f, 32'hff40001f, 32'hff40002f,
                                         32'hff40003f, 32'hff4013ff, 32'hffffffff};
   localparam logic [NS*AW-1:0] P_LO = {R_LO[8], R_LO[7], R_LO[6], R_LO[5], R_LO[4],
                                        R_LO[3], R_LO[2], R_LO[1], R_LO[0]};
   localparam logic [NS*AW-1:0] P_HI = {R_HI[8], R_HI[7], R_HI[6], R_HI[5], R_HI[4],
                                        R_HI[3], R_HI[2], R_HI[1], R_HI[0]};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bus_region_decoder_if #(.AW(AW), .NSLAVE(NS)) bus ();

   bus_region_decoder #(
      .AW(AW), .NSLAVE(NS), .LO(P_LO), .HI(P_HI), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic        m_valid;
   logic [1:0]  m_code;
   logic [31:0] m_adr;

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if (a >= R_LO[i] && a <= R_HI[i]) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one request from IDLE and follows it to completion, checking each cycle.
   // dly = select cycle (0-based) in which the target slave acks; >= TO means never.
   task automatic run_txn(input string tag, input logic [31:0] a, input int dly,
                          input logic clr, input logic noise);
      int            idx;
      logic [NS-1:0] exp_sel;
      logic          done;
      idx = decode(a);
      n_total++;
      if (bus.sel_o !== '0 || bus.err_o !== 1'b0)
         $display("FAIL %s_idle: sel=%h err=%b, want sel=0 err=0", tag, bus.sel_o, bus.err_o);
      else n_pass++;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = a; bus.fault_clr_i = clr;
      tick();
      bus.fault_clr_i = 1'b0;
      if (idx < 0) begin
         if (!m_valid || clr) begin m_valid = 1'b1; m_code = 2'b01; m_adr = a; end
         n_total++;
         if (bus.err_o !== 1'b1 || bus.sel_o !== '0)
            $display("FAIL %s_miss: err=%b sel=%h, want err=1 sel=0", tag, bus.err_o, bus.sel_o);
         else n_pass++;
         bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
         tick();
         n_total++;
         if (bus.err_o !== 1'b0 || bus.sel_o !== '0)
            $display("FAIL %s_errpulse: err=%b sel=%h, want err=0 sel=0", tag, bus.err_o, bus.sel_o);
         else n_pass++;
      end else begin
         if (clr) begin m_valid = 1'b0; m_code = 2'b00; m_adr = '0; end
         exp_sel = '0;
         exp_sel[idx] = 1'b1;
         bus.adr_i = $urandom;
         done = 1'b0;
         for (int k = 0; k < TO && !done; k++) begin
            n_total++;
            if (bus.sel_o !== exp_sel || bus.err_o !== 1'b0)
               $display("FAIL %s_sel%0d: sel=%h err=%b, want sel=%h err=0", tag, k, bus.sel_o, bus.err_o, exp_sel);
            else n_pass++;
            if (k == dly) begin
               bus.s_ack_i = exp_sel | (noise ? NS'($urandom) : '0);
               #1;
               n_total++;
               if (bus.ack_o !== 1'b1) $display("FAIL %s_ack: ack=%b, want 1", tag, bus.ack_o);
               else n_pass++;
               done = 1'b1;
            end else begin
               bus.s_ack_i = noise ? (NS'($urandom) & ~exp_sel) : '0;
               #1;
               n_total++;
               if (bus.ack_o !== 1'b0) $display("FAIL %s_noack%0d: ack=%b, want 0", tag, k, bus.ack_o);
               else n_pass++;
            end
            tick();
         end
         bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.s_ack_i = '0;
         if (done) begin
            n_total++;
            if (bus.sel_o !== '0 || bus.err_o !== 1'b0)
               $display("FAIL %s_release: sel=%h err=%b, want sel=0 err=0", tag, bus.sel_o, bus.err_o);
            else n_pass++;
         end else begin
            if (!m_valid) begin m_valid = 1'b1; m_code = 2'b10; m_adr = a; end
            n_total++;
            if (bus.sel_o !== '0 || bus.err_o !== 1'b1)
               $display("FAIL %s_timeout: sel=%h err=%b, want sel=0 err=1", tag, bus.sel_o, bus.err_o);
            else n_pass++;
            tick();
            n_total++;
            if (bus.err_o !== 1'b0)
               $display("FAIL %s_toerr: err=%b, want 0", tag, bus.err_o);
            else n_pass++;
         end
      end
      n_total++;
      if (bus.fault_valid_o !== m_valid || bus.fault_code_o !== m_code || bus.fault_adr_o !== m_adr)
         $display("FAIL %s_fault: v=%b c=%b a=%h, want v=%b c=%b a=%h", tag, bus.fault_valid_o,
                  bus.fault_code_o, bus.fault_adr_o, m_valid, m_code, m_adr);
      else n_pass++;
   endtask

   task automatic test_reset();
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.adr_i = '0; bus.s_ack_i = '0; bus.fault_clr_i = 1'b0;
      rst = 1'b1;
      tick(); tick();
      n_total++;
      if (bus.sel_o !== '0 || bus.err_o !== 1'b0 || bus.ack_o !== 1'b0 || bus.fault_valid_o !== 1'b0 ||
          bus.fault_code_o !== 2'b00 || bus.fault_adr_o !== '0)
         $display("FAIL reset: sel=%h err=%b ack=%b v=%b c=%b a=%h, want all zero", bus.sel_o, bus.err_o,
                  bus.ack_o, bus.fault_valid_o, bus.fault_code_o, bus.fault_adr_o);
      else n_pass++;
      rst = 1'b0;
      m_valid = 1'b0; m_code = 2'b00; m_adr = '0;
      tick();
   endtask

   task automatic test_read();
      run_txn("read", 32'h00000100, 3, 1'b0, 1'b0);
   endtask

   task automatic test_miss();
      run_txn("miss", 32'h00100000, 0, 1'b0, 1'b0);
      n_total++;
      if (bus.fault_code_o !== 2'b01 || bus.fault_adr_o !== 32'h00100000)
         $display("FAIL miss_code: c=%b a=%h, want 01 00100000", bus.fault_code_o, bus.fault_adr_o);
      else n_pass++;
      bus.fault_clr_i = 1'b1;
      tick();
      bus.fault_clr_i = 1'b0;
      m_valid = 1'b0; m_code = 2'b00; m_adr = '0;
      n_total++;
      if (bus.fault_valid_o !== 1'b0 || bus.fault_code_o !== 2'b00 || bus.fault_adr_o !== '0)
         $display("FAIL fault_clear: v=%b c=%b a=%h, want 0", bus.fault_valid_o, bus.fault_code_o, bus.fault_adr_o);
      else n_pass++;
   endtask

   task automatic test_timeout();
      run_txn("timeout", 32'hff400014, 100, 1'b0, 1'b0);
      n_total++;
      if (bus.fault_code_o !== 2'b10 || bus.fault_adr_o !== 32'hff400014)
         $display("FAIL to_code: c=%b a=%h, want 10 ff400014", bus.fault_code_o, bus.fault_adr_o);
      else n_pass++;
      run_txn("ack_at_limit", 32'hff400024, TO - 1, 1'b0, 1'b1);
   endtask

   task automatic test_overlap();
      run_txn("overlap", 32'h00000010, 1, 1'b0, 1'b1);
      run_txn("region1", 32'h00040000, 0, 1'b0, 1'b1);
   endtask

   task automatic test_fault_sticky();
      run_txn("sticky_clr", 32'h00000200, 0, 1'b1, 1'b0);
      run_txn("sticky_a", 32'h00100000, 0, 1'b0, 1'b0);
      run_txn("sticky_b", 32'h20000000, 0, 1'b0, 1'b0);
      n_total++;
      if (bus.fault_adr_o !== 32'h00100000)
         $display("FAIL sticky_keep: a=%h, want 00100000", bus.fault_adr_o);
      else n_pass++;
      run_txn("sticky_c", 32'h30000000, 0, 1'b1, 1'b0);
      n_total++;
      if (bus.fault_valid_o !== 1'b1 || bus.fault_adr_o !== 32'h30000000)
         $display("FAIL sticky_cap: v=%b a=%h, want 1 30000000", bus.fault_valid_o, bus.fault_adr_o);
      else n_pass++;
   endtask

   task automatic test_abort();
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 32'hfe000100;
      tick();
      tick();
      n_total++;
      if (bus.sel_o !== 9'h004) $display("FAIL abort_sel: sel=%h, want 004", bus.sel_o);
      else n_pass++;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      tick();
      n_total++;
      if (bus.sel_o !== '0 || bus.err_o !== 1'b0 || bus.fault_adr_o !== m_adr)
         $display("FAIL abort: sel=%h err=%b a=%h, want sel=0 err=0 a=%h", bus.sel_o, bus.err_o,
                  bus.fault_adr_o, m_adr);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 32'hff400020;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      n_total++;
      if (bus.sel_o !== '0 || bus.err_o !== 1'b0 || bus.fault_valid_o !== 1'b0 ||
          bus.fault_code_o !== 2'b00 || bus.fault_adr_o !== '0)
         $display("FAIL reset_mid: sel=%h err=%b v=%b c=%b a=%h, want all zero", bus.sel_o, bus.err_o,
                  bus.fault_valid_o, bus.fault_code_o, bus.fault_adr_o);
      else n_pass++;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      #1 rst = 1'b0;
      m_valid = 1'b0; m_code = 2'b00; m_adr = '0;
      tick();
   endtask

   task automatic test_random();
      logic [31:0] a;
      int          r;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) a = $urandom;
         else begin
            r = $urandom_range(0, NS - 1);
            a = R_LO[r] + ($urandom % (R_HI[r] - R_LO[r] + 32'd1));
         end
         run_txn("rand", a, $urandom_range(0, 10), ($urandom_range(0, 7) == 0), 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_read();
      test_miss();
      test_timeout();
      test_overlap();
      test_fault_sticky();
      test_abort();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/bus_region_decoder.md
Name: bus_region_decoder

Overview:
- Registered, parametrised address decoder for the CPU bus; generalises the fixed combinational memory map to NSLAVE inclusive address ranges.
- Adds a per-transaction state machine: one-hot slave select held for the whole cycle, and ack passthrough from the selected slave.
- Raises a bus error on a decode miss or on a slave timeout, and latches the faulting address in a sticky fault register for the monitor.
- Sits between the CPU bus master port and the slave muxes.

Parameters:
- AW, 32, address width.
- NSLAVE, 9, number of slave regions.
- LO, packed NSLAVE*AW, inclusive lower bound per region; slot i at bits [i*AW +: AW]. Default slots 0..8 = 0x00000000, 0x00800000, 0xfe000000, 0xff400000, 0xff400010, 0xff400020, 0xff400030, 0xff400100, 0xffc00000.
- HI, packed NSLAVE*AW, inclusive upper bound per region. Default slots 0..8 = 0x0007ffff, 0x00ffffff, 0xfe3fffff, 0xff40000f, 0xff40001f, 0xff40002f, 0xff40003f, 0xff4013ff, 0xffffffff.
- TIMEOUT, 255, cycles to wait for slave ack; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- cyc_i  in  1  master bus cycle active.
- stb_i  in  1  master strobe; held until ack_o or err_o.
- adr_i  in  AW  master address.
- s_ack_i  in  NSLAVE  per-slave ack.
- sel_o  out  NSLAVE  one-hot slave select, registered.
- ack_o  out  1  ack to master.
- err_o  out  1  bus error to master, registered one-cycle pulse.
- fault_valid_o  out  1  sticky fault flag.
- fault_code_o  out  2  01 = decode miss, 10 = timeout.
- fault_adr_o  out  AW  address of the first unacknowledged fault.
- fault_clr_i  in  1  clears the fault register.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, sel_o=0, err_o=0, counter=0.
  - fault_valid_o=0, fault_code_o=0, fault_adr_o=0.
- Decode:
  - Region i hits when LO[i] <= adr_i <= HI[i], unsigned, full AW compare.
  - Overlapping hits: lowest index wins, so sel_o is always one-hot or zero.
- Combinational output: ack_o = |(s_ack_i & sel_o). Acks from unselected slaves are ignored.
- IDLE:
  - cyc_i & stb_i with a hit: next cycle sel_o = one-hot of the winner, counter=0, state=ACTIVE. Select latency is 1 cycle; the earliest possible ack is request+1.
  - cyc_i & stb_i with a miss: next cycle err_o=1 for exactly 1 cycle, fault capture with code 01, state=ERR.
- ACTIVE:
  - ack_o=1: sel_o cleared the next cycle, state=IDLE.
  - cyc_i=0 (abort): sel_o cleared the next cycle, state=IDLE, no error.
  - Otherwise the counter increments, saturating.
  - TIMEOUT!=0 and counter reaches TIMEOUT-1 with no ack: next cycle sel_o=0, err_o=1 for 1 cycle, fault capture with code 10, state=ERR.
  - Ack and timeout in the same cycle: ack wins, no error.
- ERR: err_o=1 for this single cycle, then state=IDLE. A strobe still high on return to IDLE starts a new decode.
- Back-to-back transactions: after an ack the master may present a new strobe immediately. The decoder returns to IDLE, then registers the new select, so there is 1 idle cycle between transactions.
- Fault capture:
  - Stores adr_i as sampled at request time; it is held internally for the transaction.
  - Only occurs when fault_valid_o=0; the first fault wins and later faults are not recorded.
  - fault_clr_i=1 clears fault_valid_o, fault_code_o and fault_adr_o the next cycle.
  - Capture and clear in the same cycle: capture wins.
- Counter width is clog2(TIMEOUT+1), with a minimum of 1.
- Reset mid-transaction: all outputs return immediately to their reset values.

Test Plan:
- Read adr 0x00000100, slave0 acks 3 cycles after select.
  - Required: sel_o=0x001 at request+1; ack_o high for 1 cycle; sel_o=0 the cycle after; no err_o.
- Access adr 0x00100000 (unmapped).
  - Required: err_o pulse at request+1; fault_valid_o=1; fault_code_o=01; fault_adr_o=0x00100000; sel_o never set.
- Access adr 0xff400014 (serial0, slot 4) with no ack, TIMEOUT=8.
  - Required: sel_o=0x010 for 8 cycles, then 0; err_o pulse; fault_code_o=10.
- Region 0 and region 1 overlap at 0x00000000-0x0000ffff; access 0x00000010.
  - Required: only sel_o[0] asserted.
- Decode miss while a fault is already latched, then a miss coincident with fault_clr_i.
  - Required: the first miss leaves fault_adr_o unchanged; the coincident miss leaves the new address captured and fault_valid_o=1.
- cyc_i dropped 2 cycles into an ACTIVE transaction; separately, rst_i pulsed mid-ACTIVE.
  - Required: sel_o=0 with no err_o in both cases; reset clears the fault register.
